daq_spill_framer: RTL

- Sits directly downstream of the per-bin pulse counter.
- Takes each 32-bit bin word {live, spill, nspills[8:0], ibin[7:0], nhits[12:0]} with a one-cycle strobe and groups the in-spill words into one frame per spill: a header word, then the data words, then a trailer word.
- Frames are buffered in an internal FIFO and streamed to readout over a valid/ready interface, with out_last marking the trailer.

---
 rtl/daq_framer_pkg.sv | 38 +++
 rtl/daq_sync_fifo.sv | 80 ++++++++
 rtl/daq_spill_framer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/daq_framer_pkg.sv
// daq_framer_pkg: shared definitions for the spill framer.
//   - frame tag constants (header, normal trailer, timeout trailer)
//   - bin_word field positions as produced by the per-bin pulse counter
//   - framer FSM state encoding
//   - helpers that assemble header and trailer words
package daq_framer_pkg;

  localparam logic [3:0] HDR    = 4'hA;
  localparam logic [3:0] TRL    = 4'hC;
  localparam logic [3:0] TRL_TO = 4'hD;

  localparam int LIVE_BIT   = 31;
  localparam int SPILL_BIT  = 30;
  localparam int NSPILL_MSB = 29;
  localparam int NSPILL_LSB = 21;
  localparam int IBIN_MSB   = 20;
  localparam int IBIN_LSB   = 13;
  localparam int NHITS_MSB  = 12;
  localparam int NHITS_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SPILL = 2'd2,
    SKIP  = 2'd3
  } state_e;

  function automatic logic [31:0] make_header(input logic [8:0] nspills);
    return {HDR, 19'd0, nspills};
  endfunction

  function automatic logic [31:0] make_trailer(input logic [3:0]  tag,
                                               input logic [11:0] drops,
                                               input logic [15:0] words);
    return {tag, drops, words};
  endfunction

endpackage

// File: rtl/daq_sync_fifo.sv
// daq_sync_fifo: single-clock FIFO with a combinational head read.
//   clk, rst        clock and synchronous active-high reset (empties the FIFO)
//   push, push_data write one entry (ignored if full)
//   pop             remove the head entry (ignored if empty)
//   head            entry at the head, valid when empty=0
//   empty, count    occupancy status (count ranges 0..2**AW)
// A word pushed into an empty FIFO is visible at head the following cycle.
module daq_sync_fifo #(
  parameter int W  = 33,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [1 << AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push & (count_q != DEPTH);
  assign do_pop_s  = pop & (count_q != {(AW+1){1'b0}});

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == {(AW+1){1'b0}});
  assign count = count_q;

endmodule

// File: rtl/daq_spill_framer.sv
// daq_spill_framer: groups in-spill bin words into frames
// (header, data words, trailer) and streams them from a FIFO.
//   clk, rst              clock, synchronous active-high reset
//   bin_word, bin_valid   bin word and one-cycle strobe from the pulse counter
//   out_data, out_valid,
//   out_last, out_ready   valid/ready frame stream; out_last marks the trailer
//   drop_cnt              words dropped in the current or most recent spill
// Optional build macro DAQ_FRAMER_TIMEOUT_EN: force-close a frame with a
// 4'hD trailer after TIMEOUT_CYC cycles without a strobe.
module daq_spill_framer
  import daq_framer_pkg::*;
#(
  parameter int          FIFO_AW     = 6,
  parameter logic [31:0] TIMEOUT_CYC = 32'd2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bin_word,
  input  logic        bin_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [11:0] drop_cnt
);

  localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  // Header reserves room for itself, the first data word and the trailer;
  // each later data word reserves itself plus the trailer.
  localparam logic [FIFO_AW:0] HDR_NEED = (FIFO_AW+1)'(3);
  localparam logic [FIFO_AW:0] DAT_NEED = (FIFO_AW+1)'(2);

  state_e             state_q, state_d;
  logic [31:0]        pend_q, pend_d;
  logic [15:0]        word_cnt_q, word_cnt_d;
  logic [11:0]        drop_cnt_q, drop_cnt_d;
  logic               push_s;
  logic [32:0]        push_data_s;
  logic [32:0]        head_s;
  logic               empty_s;
  logic               pop_s;
  logic [FIFO_AW:0]   fifo_count_s;
  logic [FIFO_AW:0]   free_s;
  logic               in_spill_s;

`ifdef DAQ_FRAMER_TIMEOUT_EN
  logic [31:0]        idle_cnt_q, idle_cnt_d;
`else
  logic               unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYC;
`endif

  // Free space is taken from the registered count only; a same-cycle pop
  // does not make room for a push.
  assign free_s     = DEPTH - fifo_count_s;
  assign in_spill_s = bin_valid & bin_word[SPILL_BIT];
  assign pop_s      = out_ready & ~empty_s;

  // Framer FSM next-state and FIFO push selection.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    word_cnt_d  = word_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    push_s      = 1'b0;
    push_data_s = 33'd0;
`ifdef DAQ_FRAMER_TIMEOUT_EN
    idle_cnt_d  = 32'd0;
`endif
    case (state_q)
      IDLE: begin
        if (in_spill_s) begin
          if (free_s >= HDR_NEED) begin
            push_s      = 1'b1;
            push_data_s = {1'b0, make_header(bin_word[NSPILL_MSB:NSPILL_LSB])};
            pend_d      = bin_word;
            word_cnt_d  = 16'd0;
            drop_cnt_d  = 12'd0;
            state_d     = FIRST;
          end else begin
            state_d = SKIP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FIRST: begin
        // Strobes are at least two cycles apart, so none can arrive here.
        push_s      = 1'b1;
        push_data_s = {1'b0, pend_q};
        word_cnt_d  = 16'd1;
        state_d     = SPILL;
`ifdef DAQ_FRAMER_TIMEOUT_EN
        idle_cnt_d  = bin_valid ? 32'd0 : idle_cnt_q + 32'd1;
`endif
      end
      SPILL: begin
        if (bin_valid) begin
          if (bin_word[SPILL_BIT]) begin
            if (free_s >= DAT_NEED) begin
              push_s      = 1'b1;
              push_data_s = {1'b0, bin_word};
              word_cnt_d  = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
            end else begin
              drop_cnt_d  = (drop_cnt_q == 12'hFFF) ? drop_cnt_q : drop_cnt_q + 12'd1;
            end
          end else begin
            push_s      = 1'b1;
            push_data_s = {1'b1, make_trailer(TRL, drop_cnt_q, word_cnt_q)};
            state_d     = IDLE;
          end
`ifdef DAQ_FRAMER_TIMEOUT_EN
        end else if (idle_cnt_q >= TIMEOUT_CYC - 32'd1) begin
          // This idle cycle is the one that brings the count to the limit.
          push_s      = 1'b1;
          push_data_s = {1'b1, make_trailer(TRL_TO, drop_cnt_q, word_cnt_q)};
          state_d     = IDLE;
          idle_cnt_d  = 32'd0;
        end else begin
          idle_cnt_d  = idle_cnt_q + 32'd1;
        end
`else
        end else begin
          state_d = SPILL;
        end
`endif
      end
      SKIP: begin
        if (bin_valid && !bin_word[SPILL_BIT]) begin
          state_d = IDLE;
        end else begin
          state_d = SKIP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Framer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= 32'd0;
      word_cnt_q <= 16'd0;
      drop_cnt_q <= 12'd0;
`ifdef DAQ_FRAMER_TIMEOUT_EN
      idle_cnt_q <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef DAQ_FRAMER_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
`endif
    end
  end

  daq_sync_fifo #(
    .W  (33),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .empty     (empty_s),
    .count     (fifo_count_s)
  );

  assign out_valid = ~empty_s;
  assign out_data  = empty_s ? 32'd0 : head_s[31:0];
  assign out_last  = ~empty_s & head_s[32];
  assign drop_cnt  = drop_cnt_q;

endmodule
